// File: rtl/ahb_manager_arbiter.sv
// ahb_manager_arbiter: round-robin share of one AHB-Lite manager port
// between NUM_REQ single-transfer requesters, one transfer in flight.
module ahb_manager_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*3-1:0]            req_size,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            HSEL,
    output logic [ADDR_WIDTH-1:0]           HADDR,
    output logic [1:0]                      HTRANS,
    output logic                            HWRITE,
    output logic [2:0]                      HSIZE,
    output logic [2:0]                      HBURST,
    output logic                            HMASTLOCK,
    output logic [DATA_WIDTH-1:0]           HWDATA,
    output logic [DATA_WIDTH/8-1:0]         HWSTRB,
    input  logic                            HREADY,
    input  logic                            HRESP,
    input  logic [DATA_WIDTH-1:0]           HRDATA
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAXSZ = $clog2(SW);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t state, state_nx;

    logic [PW-1:0]         rr_ptr, gnt, gnt_c, cand;
    logic [NUM_REQ-1:0]    elig;
    logic                  any_c, legal_c, accept;
    logic [ADDR_WIDTH-1:0] c_addr, amask;
    logic [2:0]            c_size;

    logic                  l_write;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [2:0]            l_size;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic [SW-1:0]         l_wstrb;

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;

    // round-robin pick starting after the last winner; a requester whose
    // response pulses this cycle is held off so ready and response never overlap
    always_comb begin
        elig   = req_valid & ~rsp_valid;
        any_c  = 1'b0;
        gnt_c  = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_c && elig[cand]) begin
                any_c = 1'b1;
                gnt_c = cand;
            end
        end
        c_addr  = req_addr[gnt_c*ADDR_WIDTH +: ADDR_WIDTH];
        c_size  = req_size[gnt_c*3 +: 3];
        amask   = (ADDR_WIDTH'(1) << c_size) - ADDR_WIDTH'(1);
        legal_c = (c_size <= 3'(MAXSZ)) && ((c_addr & amask) == '0);
    end

    // next state and bus/handshake outputs
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        req_ready = '0;
        HSEL      = 1'b0;
        HTRANS    = 2'b00;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HSIZE     = 3'b000;
        HWDATA    = '0;
        HWSTRB    = '0;
        case (state)
            IDLE: begin
                if (any_c && !HRESET) begin
                    accept           = 1'b1;
                    req_ready[gnt_c] = 1'b1;
                    state_nx         = legal_c ? ADDR : ERR;
                end
            end
            ADDR: begin
                HSEL   = 1'b1;
                HTRANS = 2'b10;
                HADDR  = l_addr;
                HWRITE = l_write;
                HSIZE  = l_size;
                if (HREADY) state_nx = DATA;
            end
            DATA: begin
                if (l_write) begin
                    HWDATA = l_wdata;
                    HWSTRB = l_wstrb;
                end
                if (HREADY) state_nx = IDLE;
            end
            ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nx;
    end

    // request latch, arbitration pointer and registered response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_ptr    <= PW'(NUM_REQ - 1);
            gnt       <= '0;
            l_write   <= 1'b0;
            l_addr    <= '0;
            l_size    <= 3'b000;
            l_wdata   <= '0;
            l_wstrb   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (accept) begin
                rr_ptr  <= gnt_c;
                gnt     <= gnt_c;
                l_write <= req_write[gnt_c];
                l_addr  <= c_addr;
                l_size  <= c_size;
                l_wdata <= req_wdata[gnt_c*DATA_WIDTH +: DATA_WIDTH];
                l_wstrb <= req_wstrb[gnt_c*SW +: SW];
            end
            if (state == DATA && HREADY) begin
                rsp_valid[gnt] <= 1'b1;
                rsp_err        <= HRESP;
                rsp_rdata      <= l_write ? '0 : HRDATA;
            end
            if (state == ERR) begin
                rsp_valid[gnt] <= 1'b1;
                rsp_err        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// tb_ahb_manager_arbiter: directed AHB arbiter scenarios followed by
// randomized traffic checked against a transaction-level model.
module tb_ahb_manager_arbiter;

    localparam int N = 2;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [N-1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*3-1:0]  req_size;
    logic [N*4-1:0]  req_wstrb;
    logic [31:0]   rsp_rdata, HADDR, HWDATA, HRDATA;
    logic          rsp_err, HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HWSTRB;

    int tests = 0;
    int fails = 0;

    ahb_manager_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d, input logic [3:0] st);
        req_valid[i]        = v;
        req_write[i]        = w;
        req_addr[i*32 +: 32] = a;
        req_size[i*3 +: 3]  = s;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4] = st;
    endtask

    // transaction-level model state for the random phase
    logic        pend [N];
    logic        p_w  [N];
    logic [31:0] p_a  [N];
    logic [2:0]  p_s  [N];
    logic [31:0] p_d  [N];
    logic [3:0]  p_st [N];

    initial begin
        int order[$];
        int pulses, g, last, ph, own, rown;
        logic rv, rerr, nrv, nerr, mw;
        logic [31:0] rdat, ndat, ma, md;
        logic [2:0] ms;
        logic [N-1:0] exp_rdy;

        HRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
        req_size = '0; req_wdata = '0; req_wstrb = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        tick(); tick();
        HRESET = 1'b0;
        #1;
        check("reset_htrans", HTRANS, 2'b00);
        check("reset_hsel", HSEL, 1'b0);
        check("reset_ready", req_ready, 2'b00);
        check("reset_rsp", rsp_valid, 2'b00);
        check("reset_haddr", HADDR, 32'h0);

        // read, zero wait states
        tick();
        set_req(0, 1, 0, 32'h1000, 3'd2, 32'h0, 4'h0);
        #1 check("rd_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1 check("rd_htrans", HTRANS, 2'b10);
        check("rd_haddr", HADDR, 32'h1000);
        check("rd_hsel", HSEL, 1'b1);
        check("rd_hwrite", HWRITE, 1'b0);
        check("rd_hsize", HSIZE, 3'd2);
        tick();
        HRDATA = 32'hDEADBEEF;
        #1 check("rd_data_htrans", HTRANS, 2'b00);
        check("rd_data_hwstrb", HWSTRB, 4'h0);
        check("rd_early_rsp", rsp_valid, 2'b00);
        tick();
        HRDATA = 32'h0;
        #1 check("rd_rsp", rsp_valid, 2'b01);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", rsp_err, 1'b0);
        tick();
        #1 check("rd_rsp_once", rsp_valid, 2'b00);

        // write with two data-phase wait states
        tick();
        set_req(1, 1, 1, 32'h20, 3'd2, 32'hA5A5A5A5, 4'hF);
        #1 check("wr_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        #1 check("wr_haddr", HADDR, 32'h20);
        check("wr_hwrite", HWRITE, 1'b1);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            HREADY = (c == 2);
            #1 check("wr_hwdata", HWDATA, 32'hA5A5A5A5);
            check("wr_hwstrb", HWSTRB, 4'hF);
            check("wr_htrans", HTRANS, 2'b00);
            if (rsp_valid != 0) pulses++;
        end
        tick();
        #1 check("wr_rsp", rsp_valid, 2'b10);
        check("wr_err", rsp_err, 1'b0);
        check("wr_rdata", rsp_rdata, 32'h0);
        pulses++;
        tick();
        #1 if (rsp_valid != 0) pulses++;
        check("wr_pulses", pulses, 1);

        // round robin with both requesters always valid
        tick();
        set_req(0, 1, 0, 32'h100, 3'd2, 32'h0, 4'h0);
        set_req(1, 1, 0, 32'h200, 3'd2, 32'h0, 4'h0);
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            #1;
            if (req_ready == 2'b01) order.push_back(0);
            if (req_ready == 2'b10) order.push_back(1);
            tick();
        end
        req_valid = '0;
        check("rr_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            check("rr_order", (i < order.size()) ? order[i] : -1, i % 2);
        repeat (5) tick();

        // two-cycle error response
        set_req(0, 1, 0, 32'h40, 3'd2, 32'h0, 4'h0);
        #1 check("er_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        HRESP = 1'b1; HREADY = 1'b0;
        pulses = 0;
        #1 if (rsp_valid != 0) pulses++;
        tick();
        HREADY = 1'b1;
        #1 if (rsp_valid != 0) pulses++;
        tick();
        HRESP = 1'b0;
        #1 check("er_rsp", rsp_valid, 2'b01);
        check("er_err", rsp_err, 1'b1);
        if (rsp_valid != 0) pulses++;
        tick();
        #1 if (rsp_valid != 0) pulses++;
        check("er_pulses", pulses, 1);

        // illegal: misaligned, then oversize
        for (int t = 0; t < 2; t++) begin
            tick();
            set_req(t, 1, 0, t == 0 ? 32'h1002 : 32'h1000,
                    t == 0 ? 3'd2 : 3'd3, 32'h0, 4'h0);
            #1 check("il_ready", req_ready, t == 0 ? 2'b01 : 2'b10);
            tick();
            req_valid = '0;
            #1 check("il_htrans", HTRANS, 2'b00);
            check("il_hsel", HSEL, 1'b0);
            tick();
            #1 check("il_rsp", rsp_valid, t == 0 ? 2'b01 : 2'b10);
            check("il_err", rsp_err, 1'b1);
            check("il_rdata", rsp_rdata, 32'h0);
        end

        // reset during a stalled address phase
        tick();
        set_req(0, 1, 0, 32'h80, 3'd2, 32'h0, 4'h0);
        #1 check("rs_ready", req_ready, 2'b01);
        tick();
        req_valid = '0; HREADY = 1'b0; HRESET = 1'b1;
        #1 check("rs_addr_phase", HTRANS, 2'b10);
        tick();
        HRESET = 1'b0; HREADY = 1'b1;
        #1 check("rs_htrans", HTRANS, 2'b00);
        check("rs_hsel", HSEL, 1'b0);
        check("rs_rsp", rsp_valid, 2'b00);
        tick();
        set_req(0, 1, 0, 32'h84, 3'd2, 32'h0, 4'h0);
        set_req(1, 1, 0, 32'h88, 3'd2, 32'h0, 4'h0);
        #1 check("rs_rsp2", rsp_valid, 2'b00);
        check("rs_first", req_ready, 2'b01);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // randomized traffic against the transaction model
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        last = N - 1; ph = 0; own = 0; rown = 0;
        rv = 1'b0; rerr = 1'b0; rdat = '0;
        mw = 1'b0; ma = '0; ms = '0; md = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p_w[i]  = 1'($urandom_range(0, 1));
                    p_s[i]  = 3'($urandom_range(0, 3));
                    p_a[i]  = $urandom;
                    if ($urandom_range(0, 3) != 0)
                        p_a[i] = p_a[i] - (p_a[i] % (32'd1 << p_s[i]));
                    p_d[i]  = $urandom;
                    p_st[i] = 4'($urandom_range(0, 15));
                end
                set_req(i, pend[i], p_w[i], p_a[i], p_s[i], p_d[i], p_st[i]);
            end
            HREADY = ($urandom_range(0, 3) != 0);
            HRESP  = ($urandom_range(0, 5) == 0);
            HRDATA = $urandom;
            #1;
            g = -1;
            exp_rdy = '0;
            if (ph == 0)
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (last + k) % N;
                    if (g < 0 && pend[j] && !(rv && rown == j)) g = j;
                end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("rnd_ready", req_ready, exp_rdy);
            check("rnd_htrans", HTRANS, ph == 1 ? 2'b10 : 2'b00);
            if (ph == 1) begin
                check("rnd_haddr", HADDR, ma);
                check("rnd_hwrite", HWRITE, mw);
                check("rnd_hsize", HSIZE, ms);
            end
            if (ph == 2)
                check("rnd_hwdata", HWDATA, mw ? md : 32'h0);
            check("rnd_rsp", rsp_valid, rv ? (N'(1) << rown) : '0);
            if (rv) begin
                check("rnd_err", rsp_err, rerr);
                check("rnd_rdata", rsp_rdata, rdat);
            end
            nrv = 1'b0; nerr = 1'b0; ndat = '0;
            case (ph)
                0: if (g >= 0) begin
                    last = g; own = g; pend[g] = 1'b0;
                    mw = p_w[g]; ma = p_a[g]; ms = p_s[g]; md = p_d[g];
                    ph = (ms <= 2 && ma % (32'd1 << ms) == 0) ? 1 : 3;
                end
                1: if (HREADY) ph = 2;
                2: if (HREADY) begin
                    nrv = 1'b1; nerr = HRESP; ndat = mw ? 32'h0 : HRDATA;
                    ph = 0;
                end
                default: begin
                    nrv = 1'b1; nerr = 1'b1; ph = 0;
                end
            endcase
            if (nrv) rown = own;
            rv = nrv; rerr = nerr; rdat = ndat;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
